// File: rtl/score_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : score_accumulator_if
// Description : Award handshake, BCD adder hookup and HUD outputs of the
//               score accumulator, grouped into one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_accumulator_if;
    // Game-control side
    logic        new_game;
    logic        award_valid;
    logic [15:0] award_bcd;
    logic        award_ready;

    // External 4-digit BCD adder
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_s;
    logic        add_co;

    // HUD / status
    logic [15:0] score;
    logic [15:0] hiscore;
    logic        saturated;
    logic        busy;

    // Environment side: game logic plus the adder
    modport master (
        output new_game,
        output award_valid,
        output award_bcd,
        input  award_ready,
        input  add_a,
        input  add_b,
        output add_s,
        output add_co,
        input  score,
        input  hiscore,
        input  saturated,
        input  busy
    );

    // Accumulator side
    modport slave (
        input  new_game,
        input  award_valid,
        input  award_bcd,
        output award_ready,
        output add_a,
        output add_b,
        input  add_s,
        input  add_co,
        output score,
        output hiscore,
        output saturated,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/score_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : score_accumulator
// Description : Queues packed-BCD point awards, adds them one at a time to
//               the running score through an external combinational BCD
//               adder, saturates at SAT_VALUE on decimal overflow and keeps
//               the high score since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module score_accumulator #(
    parameter int          FIFO_DEPTH = 4,        // power of two, >= 2
    parameter logic [15:0] SAT_VALUE  = 16'h9999
) (
    input  wire logic      Clk,
    input  wire logic      Reset,
    score_accumulator_if.slave bus
);

    localparam int                 c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_count_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;

    state_t             r_state;
    logic [15:0]        r_score;
    logic [15:0]        r_hiscore;
    logic [15:0]        r_award_q;
    logic               r_saturated;

    logic               w_full;
    logic               w_award_ok;
    logic               w_push;
    logic               w_pop;

    // True when every nibble of a packed BCD word is a decimal digit.
    function automatic logic bcd_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Queue control. Ready comes from the count at the start of the cycle,
    // so a full queue refuses a push even when the FSM pops that cycle.
    // Malformed awards still see ready and complete the handshake, they
    // simply never get written.
    // ------------------------------------------------------------------
    assign w_full     = (r_count == c_full_count);
    assign w_award_ok = bcd_ok(bus.award_bcd);
    assign w_push     = bus.award_valid && !w_full && w_award_ok && !bus.new_game;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);

    // Award storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.award_bcd;
        end
    end

    // Queue pointers and occupancy; new_game flushes like a reset.
    always_ff @(posedge Clk) begin
        if (Reset || bus.new_game) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Three-cycle award FSM: pop -> add -> high-score compare.
    // The hiscore compare sits outside the new_game branch so that a
    // new_game landing in CMP still records the score it is about to clear.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_score     <= '0;
            r_hiscore   <= '0;
            r_award_q   <= '0;
            r_saturated <= 1'b0;
        end else begin
            if ((r_state == S_CMP) && (r_score > r_hiscore)) begin
                r_hiscore <= r_score;
            end

            if (bus.new_game) begin
                r_state     <= S_IDLE;
                r_score     <= '0;
                r_award_q   <= '0;
                r_saturated <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            r_award_q <= r_mem[r_rd_ptr];
                            r_state   <= S_ADD;
                        end
                    end
                    S_ADD: begin
                        // Once clipped, awards are consumed without effect.
                        if (!r_saturated) begin
                            if (bus.add_co) begin
                                r_score     <= SAT_VALUE;
                                r_saturated <= 1'b1;
                            end else begin
                                r_score <= bus.add_s;
                            end
                        end
                        r_state <= S_CMP;
                    end
                    S_CMP: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the adder always sees the live score and current award.
    // ------------------------------------------------------------------
    assign bus.award_ready = !w_full;
    assign bus.add_a       = r_score;
    assign bus.add_b       = r_award_q;
    assign bus.score       = r_score;
    assign bus.hiscore     = r_hiscore;
    assign bus.saturated   = r_saturated;
    assign bus.busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire
